// File: rtl/acq_pkg.sv
// Shared definitions for the capture buffer: register map, trigger sources and FSM states.
package acq_pkg;

    localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
    localparam logic [31:0] REG_TRGSRC = 32'h0000_0004;
    localparam logic [31:0] REG_DEC    = 32'h0000_0008;
    localparam logic [31:0] REG_POST   = 32'h0000_000C;
    localparam logic [31:0] REG_WPTR   = 32'h0000_0010;
    localparam logic [31:0] REG_TPTR   = 32'h0000_0014;
    localparam logic [31:0] REG_STATUS = 32'h0000_0018;
    localparam logic [15:0] RAM_PAGE   = 16'h0001;

    typedef enum logic [2:0] {
        TRIG_NONE = 3'd0,
        TRIG_SW   = 3'd1,
        TRIG_EXT  = 3'd2,
        TRIG_ASG  = 3'd3
    } trig_src_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        POST,
        DONE
    } acq_state_t;

    // Decimation values 0 and 1 both keep every sample.
    function automatic logic dec_hit(input logic [16:0] cnt, input logic [16:0] dec);
        return (dec <= 17'd1) || (cnt == dec - 17'd1);
    endfunction

endpackage

// File: rtl/acq_ram.sv
// Simple dual-port sample memory with a registered read port.
module acq_ram #(
    parameter int DW = 14,
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/red_pitaya_acq_buf.sv
// Single-channel trigger-centred capture buffer with a sys-bus register and RAM window.
module red_pitaya_acq_buf
    import acq_pkg::*;
#(
    parameter int DW  = 14,
    parameter int RSZ = 14
) (
    input  logic          adc_clk_i,
    input  logic          adc_rst_i,
    input  logic [DW-1:0] adc_dat_i,
    input  logic          trig_ext_i,
    input  logic          trig_asg_i,
    input  logic [31:0]   sys_addr,
    input  logic [31:0]   sys_wdata,
    input  logic [3:0]    sys_sel,
    input  logic          sys_wen,
    input  logic          sys_ren,
    output logic [31:0]   sys_rdata,
    output logic          sys_err,
    output logic          sys_ack,
    output logic          trig_o
);

    acq_state_t     state;
    logic           ext_q, asg_q;
    logic [2:0]     trgsrc;
    logic [16:0]    dec, dec_cnt;
    logic [31:0]    post, post_cnt;
    logic [RSZ-1:0] wptr, tptr, wptr_next;
    logic           armed, triggered, done;
    logic           ram_sel, ctrl_wr, arm, abort, sw_trig, trig_evt;
    logic           capturing, post_reached, store, ram_rd_q;
    logic [DW-1:0]  ram_rdata;
    logic [31:0]    reg_rdata;
    logic           unused_sel;

    assign unused_sel   = ^sys_sel;
    assign sys_err      = 1'b0;
    assign ram_sel      = (sys_addr[31:16] == RAM_PAGE);
    assign ctrl_wr      = sys_wen && (sys_addr == REG_CTRL);
    assign arm          = ctrl_wr && sys_wdata[0];
    assign abort        = ctrl_wr && sys_wdata[1];
    assign sw_trig      = ctrl_wr && sys_wdata[2];
    assign capturing    = (state == ARMED) || (state == POST);
    assign post_reached = (state == POST) && (post_cnt == post);
    assign store        = capturing && !abort && !arm && !post_reached && dec_hit(dec_cnt, dec);
    // tptr marks the first sample stored after the trigger, hence the post-store pointer.
    assign wptr_next    = wptr + {{(RSZ-1){1'b0}}, store};

    always_comb begin
        trig_evt = 1'b0;
        case (trig_src_t'(trgsrc))
            TRIG_SW:  trig_evt = sw_trig;
            TRIG_EXT: trig_evt = trig_ext_i && !ext_q;
            TRIG_ASG: trig_evt = trig_asg_i && !asg_q;
            default:  trig_evt = 1'b0;
        endcase
    end

    always_comb begin
        reg_rdata = 32'd0;
        case (sys_addr)
            REG_TRGSRC: reg_rdata = {29'd0, trgsrc};
            REG_DEC:    reg_rdata = {15'd0, dec};
            REG_POST:   reg_rdata = post;
            REG_WPTR:   reg_rdata = {{(32-RSZ){1'b0}}, wptr};
            REG_TPTR:   reg_rdata = {{(32-RSZ){1'b0}}, tptr};
            REG_STATUS: reg_rdata = {29'd0, done, triggered, armed};
            default:    reg_rdata = 32'd0;
        endcase
    end

    acq_ram #(.DW(DW), .AW(RSZ)) u_ram (
        .clk   (adc_clk_i),
        .we    (store),
        .waddr (wptr),
        .wdata (adc_dat_i),
        .raddr (sys_addr[RSZ+1:2]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state     <= IDLE;
            ext_q     <= 1'b0;
            asg_q     <= 1'b0;
            trgsrc    <= '0;
            dec       <= '0;
            dec_cnt   <= '0;
            post      <= '0;
            post_cnt  <= '0;
            wptr      <= '0;
            tptr      <= '0;
            armed     <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
            trig_o    <= 1'b0;
        end else begin
            ext_q  <= trig_ext_i;
            asg_q  <= trig_asg_i;
            trig_o <= 1'b0;
            if (sys_wen) begin
                case (sys_addr)
                    REG_TRGSRC: trgsrc <= sys_wdata[2:0];
                    REG_DEC:    dec    <= sys_wdata[16:0];
                    REG_POST:   post   <= sys_wdata;
                    default:    ;
                endcase
            end
            if (capturing && !post_reached) begin
                dec_cnt <= dec_hit(dec_cnt, dec) ? 17'd0 : dec_cnt + 17'd1;
            end
            wptr <= wptr_next;
            // Abort outranks arm, and arm outranks any trigger in the same cycle.
            if (abort) begin
                state     <= IDLE;
                armed     <= 1'b0;
                triggered <= 1'b0;
                done      <= 1'b0;
            end else if (arm) begin
                state     <= ARMED;
                wptr      <= '0;
                dec_cnt   <= '0;
                post_cnt  <= '0;
                armed     <= 1'b1;
                triggered <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state)
                    ARMED: begin
                        if (trig_evt) begin
                            tptr      <= wptr_next;
                            post_cnt  <= '0;
                            trig_o    <= 1'b1;
                            triggered <= 1'b1;
                            state     <= POST;
                        end
                    end
                    POST: begin
                        if (post_reached) begin
                            state     <= DONE;
                            triggered <= 1'b0;
                            done      <= 1'b1;
                        end else if (store) begin
                            post_cnt <= post_cnt + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register accesses answer after one cycle, RAM reads after two (registered RAM port).
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            sys_ack   <= 1'b0;
            sys_rdata <= 32'd0;
            ram_rd_q  <= 1'b0;
        end else begin
            ram_rd_q <= sys_ren && ram_sel;
            sys_ack  <= 1'b0;
            if (ram_rd_q) begin
                sys_ack   <= 1'b1;
                sys_rdata <= {{(32-DW){ram_rdata[DW-1]}}, ram_rdata};
            end else if ((sys_ren && !ram_sel) || sys_wen) begin
                sys_ack   <= 1'b1;
                sys_rdata <= sys_ren ? reg_rdata : 32'd0;
            end
        end
    end

endmodule
